i2c_scl_generator: RTL and testbench
====================================

Name: i2c_scl_generator

Overview:
Parametrised SCL generator for the I2C master: produces SCL from i2c_core_clk_i with independently programmable high and low phase lengths. Supports slave clock stretching with a timeout, and graceful stop on disable (never truncates a low phase). Emits one-cycle phase-event strobes (edges, mid-high sample point, mid-low drive point) consumed by the byte/bit controller FSM.

Parameters:
PRESCALE_W, 16, width of thigh_i/tlow_i phase-length inputs and phase counter
STRETCH_W, 20, width of stretch_limit_i and stretch counter

Ports:
i2c_core_clk_i  input  1  i2c core clock, sole clock
reset_i  input  1  synchronous, active-high reset
clk_en_i  input  1  run SCL; deassert = finish current phase then park high
thigh_i  input  PRESCALE_W  SCL high phase length in core cycles (0 treated as 1)
tlow_i  input  PRESCALE_W  SCL low phase length in core cycles (0 treated as 1)
stretch_en_i  input  1  1 = wait for scl_i high after release before counting high phase
scl_i  input  1  bus SCL level, already synchronised externally
stretch_limit_i  input  STRETCH_W  max stretch cycles; 0 = no timeout
i2c_scl_o  output  1  SCL drive value (1 = release/high, 0 = pull low)
scl_fall_o  output  1  one-cycle pulse on the cycle i2c_scl_o goes 1->0
scl_rise_o  output  1  one-cycle pulse on the first cycle of HIGH phase
sample_tick_o  output  1  pulse at high-phase midpoint
drive_tick_o  output  1  pulse at low-phase midpoint
stretching_o  output  1  level, 1 while in WAIT_HIGH
stretch_timeout_o  output  1  sticky timeout flag
idle_o  output  1  level, 1 in IDLE

Behaviour:
- Reset (sync, priority over everything): state IDLE, i2c_scl_o=1, counters 0, all pulses 0, stretching_o=0, stretch_timeout_o=0, idle_o=1.
- All outputs registered; latencies below are from the rising clock edge on which the condition is sampled.
- States: IDLE, HIGH, LOW, WAIT_HIGH.
- IDLE: i2c_scl_o=1. On clk_en_i=1 and stretch_timeout_o=0 -> HIGH, counter=0, latch th=max(thigh_i,1). No scl_rise_o on this entry.
- HIGH: i2c_scl_o=1, counter increments each cycle.
  - sample_tick_o pulses the cycle counter==th>>1.
  - At counter==th-1: if clk_en_i=1 -> LOW, i2c_scl_o=0, scl_fall_o pulse, counter=0, latch tl=max(tlow_i,1); else -> IDLE.
- LOW: i2c_scl_o=0, counter increments. drive_tick_o pulses at counter==tl>>1. At counter==tl-1, i2c_scl_o=1 (release):
  - stretch_en_i=1 -> WAIT_HIGH, stretch counter=0.
  - else clk_en_i=1 -> HIGH, scl_rise_o pulse, counter=0, latch th.
  - else -> IDLE.
  - clk_en_i is ignored mid-LOW; the low phase always completes.
- WAIT_HIGH: i2c_scl_o=1, stretching_o=1, stretch counter increments.
  - scl_i=1 -> HIGH (or IDLE if clk_en_i=0). scl_rise_o pulses only when entering HIGH. Counter=0, latch th.
  - stretch_limit_i!=0 and stretch counter==stretch_limit_i-1 with scl_i=0 -> IDLE, stretch_timeout_o=1.
  - Simultaneous scl_i=1 and limit reached: scl_i wins; no timeout.
- stretch_timeout_o clears only on reset or on a cycle with clk_en_i=0. While set, IDLE does not restart.
- thigh_i/tlow_i are sampled only at phase entry; mid-phase changes take effect next phase.
- th=1: sample_tick_o on the first high cycle; tl=1: drive_tick_o on the single low cycle. Period without stretch = th+tl cycles exactly.
- Counters are never compared beyond latched length; no wrap-around is possible.

Decomposition:
- Package i2c_clk_pkg: state encoding (IDLE/HIGH/LOW/WAIT_HIGH), default PRESCALE_W/STRETCH_W constants.
- One natural sub-module: i2c_phase_counter (load length, count, emit mid and terminal strobes), instantiated once and reused for HIGH/LOW phases.
- Stretch counter stays inline.

Test Plan:
- thigh=4, tlow=6, stretch_en=0, clk_en held 1 -> SCL high 4 / low 6 cycles, period 10; scl_fall every 10 cycles; sample_tick at high cycle 2, drive_tick at low cycle 3.
- thigh=0, tlow=0 -> treated as 1/1; SCL toggles every cycle, every pulse fires each phase.
- stretch_en=1, scl_i held low 25 cycles after release, limit=0 -> stretching_o=1 for 25 cycles; scl_rise_o the cycle after scl_i rises; then 4-cycle high.
- stretch_en=1, limit=8, scl_i stuck low -> stretch_timeout_o=1 after 8 WAIT_HIGH cycles, idle_o=1, SCL released; stays idle until clk_en_i=0 for 1 cycle clears flag.
- clk_en_i dropped 2 cycles into a 6-cycle low phase -> low completes (6 cycles), SCL returns 1, idle_o=1, no further scl_fall.
- reset_i asserted mid-LOW -> next cycle i2c_scl_o=1, idle_o=1, all pulses 0, timeout cleared.

Source files
------------

// File: rtl/i2c_clk_pkg.sv
// Shared definitions for the I2C SCL generator.
//   scl_state_e   : SCL generator FSM states
//   DefPrescaleW  : default width of the phase-length inputs and phase counter
//   DefStretchW   : default width of the stretch limit and stretch counter
package i2c_clk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StWaitHigh
    } scl_state_e;

    localparam int unsigned DefPrescaleW = 16;
    localparam int unsigned DefStretchW  = 20;

endpackage

// File: rtl/i2c_phase_counter.sv
// Phase counter shared by the SCL high and low phases.
// On load_i it latches max(len_i, 1) and restarts at 0; otherwise it counts up and
// holds at the terminal value (len-1), so it never runs past the latched length.
//   i2c_core_clk_i : core clock
//   reset_i        : synchronous active-high reset
//   load_i         : start a new phase this edge
//   len_i          : raw phase length (0 treated as 1), sampled only on load_i
//   mid_next_o     : the count after this edge equals len>>1 (combinational lookahead)
//   last_o         : registered, the current count is the terminal count len-1
module i2c_phase_counter
    import i2c_clk_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DefPrescaleW
) (
    input  logic                  i2c_core_clk_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [PRESCALE_W-1:0] len_i,
    output logic                  mid_next_o,
    output logic                  last_o
);

    logic [PRESCALE_W-1:0] len_q, len_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  last_q;

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (load_i) begin
            len_d = (len_i == '0) ? PRESCALE_W'(1) : len_i;
            cnt_d = '0;
        end else if (cnt_q != len_q - PRESCALE_W'(1)) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    // Lookahead lets the parent register its tick outputs so they line up with the count.
    assign mid_next_o = (cnt_d == (len_d >> 1));
    assign last_o     = last_q;

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            len_q  <= PRESCALE_W'(1);
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            last_q <= (cnt_d == len_d - PRESCALE_W'(1));
        end
    end

endmodule

// File: rtl/i2c_scl_generator.sv
// SCL generator for the I2C master. Produces SCL with programmable high/low phase
// lengths, supports slave clock stretching with an optional timeout, and finishes the
// current phase before parking high when disabled. All outputs are registered.
//   i2c_core_clk_i    : core clock
//   reset_i           : synchronous active-high reset
//   clk_en_i          : run SCL; low = finish current phase then park high
//   thigh_i / tlow_i  : high / low phase length in core cycles (0 treated as 1)
//   stretch_en_i      : wait for scl_i high after release before the high phase
//   scl_i             : synchronised bus SCL level
//   stretch_limit_i   : max stretch cycles, 0 = unlimited
//   i2c_scl_o         : SCL drive value (1 = release)
//   scl_fall_o        : pulse on the first low cycle
//   scl_rise_o        : pulse on the first high cycle after a low phase / stretch
//   sample_tick_o     : pulse at the high-phase midpoint
//   drive_tick_o      : pulse at the low-phase midpoint
//   stretching_o      : level, waiting for the slave to release SCL
//   stretch_timeout_o : sticky stretch timeout flag
//   idle_o            : level, generator parked
module i2c_scl_generator
    import i2c_clk_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DefPrescaleW,
    parameter int unsigned STRETCH_W  = DefStretchW
) (
    input  logic                  i2c_core_clk_i,
    input  logic                  reset_i,
    input  logic                  clk_en_i,
    input  logic [PRESCALE_W-1:0] thigh_i,
    input  logic [PRESCALE_W-1:0] tlow_i,
    input  logic                  stretch_en_i,
    input  logic                  scl_i,
    input  logic [STRETCH_W-1:0]  stretch_limit_i,
    output logic                  i2c_scl_o,
    output logic                  scl_fall_o,
    output logic                  scl_rise_o,
    output logic                  sample_tick_o,
    output logic                  drive_tick_o,
    output logic                  stretching_o,
    output logic                  stretch_timeout_o,
    output logic                  idle_o
);

    scl_state_e            state_q, state_d;
    logic [STRETCH_W-1:0]  scnt_q, scnt_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_evt;
    logic                  scl_q, fall_q, rise_q, sample_q, drive_q, stretching_q, idle_q;

    logic                  pc_load;
    logic [PRESCALE_W-1:0] pc_len;
    logic                  pc_mid_next;
    logic                  pc_last;

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        timeout_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clk_en_i && !timeout_q) state_d = StHigh;
            end
            StHigh: begin
                if (pc_last) state_d = clk_en_i ? StLow : StIdle;
            end
            StLow: begin
                // clk_en_i only matters at the end: a low phase is never truncated.
                if (pc_last) begin
                    if (stretch_en_i) begin
                        state_d = StWaitHigh;
                        scnt_d  = '0;
                    end else if (clk_en_i) begin
                        state_d = StHigh;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitHigh: begin
                if (scnt_q != '1) scnt_d = scnt_q + STRETCH_W'(1);
                // A released bus wins over a limit reached on the same cycle.
                if (scl_i) begin
                    state_d = clk_en_i ? StHigh : StIdle;
                end else if (stretch_limit_i != '0 &&
                             scnt_q == stretch_limit_i - STRETCH_W'(1)) begin
                    state_d     = StIdle;
                    timeout_evt = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky: a timeout on the same cycle as clk_en_i=0 still sets the flag.
    always_comb begin
        timeout_d = timeout_q;
        if (timeout_evt)    timeout_d = 1'b1;
        else if (!clk_en_i) timeout_d = 1'b0;
    end

    assign pc_load = (state_d != state_q) && (state_d == StHigh || state_d == StLow);
    assign pc_len  = (state_d == StLow) ? tlow_i : thigh_i;

    i2c_phase_counter #(
        .PRESCALE_W(PRESCALE_W)
    ) u_phase_counter (
        .i2c_core_clk_i(i2c_core_clk_i),
        .reset_i       (reset_i),
        .load_i        (pc_load),
        .len_i         (pc_len),
        .mid_next_o    (pc_mid_next),
        .last_o        (pc_last)
    );

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            scnt_q       <= '0;
            timeout_q    <= 1'b0;
            scl_q        <= 1'b1;
            fall_q       <= 1'b0;
            rise_q       <= 1'b0;
            sample_q     <= 1'b0;
            drive_q      <= 1'b0;
            stretching_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            timeout_q    <= timeout_d;
            scl_q        <= (state_d != StLow);
            fall_q       <= (state_d == StLow) && (state_q == StHigh);
            rise_q       <= (state_d == StHigh) &&
                            (state_q == StLow || state_q == StWaitHigh);
            sample_q     <= (state_d == StHigh) && pc_mid_next;
            drive_q      <= (state_d == StLow) && pc_mid_next;
            stretching_q <= (state_d == StWaitHigh);
            idle_q       <= (state_d == StIdle);
        end
    end

    assign i2c_scl_o         = scl_q;
    assign scl_fall_o        = fall_q;
    assign scl_rise_o        = rise_q;
    assign sample_tick_o     = sample_q;
    assign drive_tick_o      = drive_q;
    assign stretching_o      = stretching_q;
    assign stretch_timeout_o = timeout_q;
    assign idle_o            = idle_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Bench for i2c_scl_generator. Each scenario is described as a sequence of SCL phases
// (idle, high, low, stretch, timeout); the phases are expanded into a per-cycle list of
// stimulus and expected outputs, which is then replayed against the DUT.
// Expected output vector bit order: {scl, fall, rise, sample, drive, stretching, timeout, idle}.
module tb_i2c_scl_generator;

    typedef struct packed {
        logic        en;
        logic        sin;
        logic [15:0] th;
        logic [15:0] tl;
        logic [7:0]  exp;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic [15:0] thigh_i;
    logic [15:0] tlow_i;
    logic        stretch_en_i;
    logic        scl_i;
    logic [19:0] stretch_limit_i;
    logic        i2c_scl_o, scl_fall_o, scl_rise_o, sample_tick_o, drive_tick_o;
    logic        stretching_o, stretch_timeout_o, idle_o;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];

    i2c_scl_generator #(
        .PRESCALE_W(16),
        .STRETCH_W (20)
    ) dut (
        .i2c_core_clk_i   (clk),
        .reset_i          (reset_i),
        .clk_en_i         (clk_en_i),
        .thigh_i          (thigh_i),
        .tlow_i           (tlow_i),
        .stretch_en_i     (stretch_en_i),
        .scl_i            (scl_i),
        .stretch_limit_i  (stretch_limit_i),
        .i2c_scl_o        (i2c_scl_o),
        .scl_fall_o       (scl_fall_o),
        .scl_rise_o       (scl_rise_o),
        .sample_tick_o    (sample_tick_o),
        .drive_tick_o     (drive_tick_o),
        .stretching_o     (stretching_o),
        .stretch_timeout_o(stretch_timeout_o),
        .idle_o           (idle_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: phase sequence -> per-cycle expectations --------

    function automatic void push(logic en, logic sin, logic [7:0] exp);
        ent_t e;
        e.en  = en;
        e.sin = sin;
        e.th  = 16'($urandom_range(0, 15));  // noise: lengths matter only at phase entry
        e.tl  = 16'($urandom_range(0, 15));
        e.exp = exp;
        q.push_back(e);
    endfunction

    // The length of a new phase is what the input holds on the cycle before it starts.
    function automatic void patch_len(bit is_low, int len);
        ent_t e;
        e = q[q.size()-1];
        if (is_low) e.tl = 16'(len);
        else        e.th = 16'(len);
        q[q.size()-1] = e;
    endfunction

    function automatic void gen_idle(int n, bit en, bit to);
        for (int i = 0; i < n; i++) push(en, 1'b1, {6'b100000, to, 1'b1});
    endfunction

    function automatic void gen_high(int len, bit rise, bit en);
        int eff;
        eff = (len == 0) ? 1 : len;
        patch_len(1'b0, len);
        for (int i = 0; i < eff; i++)
            push(en, 1'b1, {1'b1, 1'b0, (rise && i == 0), (i == eff / 2), 4'b0000});
    endfunction

    // clk_en is driven low from low-cycle drop_at onwards.
    function automatic void gen_low(int len, int drop_at);
        int eff;
        eff = (len == 0) ? 1 : len;
        patch_len(1'b1, len);
        for (int i = 0; i < eff; i++)
            push((i < drop_at), 1'b1, {1'b0, (i == 0), 1'b0, 1'b0, (i == eff / 2), 3'b000});
    endfunction

    // Slave holds SCL low; the bus reads high on the n-th waiting cycle.
    function automatic void gen_wait(int n, bit en);
        for (int j = 0; j < n; j++) push(en, (j == n - 1), 8'b1000_0100);
    endfunction

    function automatic void gen_timeout(int limit);
        for (int j = 0; j < limit; j++) push(1'b1, 1'b0, 8'b1000_0100);
    endfunction

    // ---------------- drivers ----------------

    task automatic do_reset(input logic en_during);
        reset_i  = 1'b1;
        clk_en_i = en_during;
        scl_i    = 1'b0;
        @(posedge clk);
        #1;
        reset_i  = 1'b0;
        clk_en_i = 1'b0;
        scl_i    = 1'b1;
    endtask

    task automatic apply_cycle(input ent_t e, output logic [7:0] obs);
        clk_en_i = e.en;
        scl_i    = e.sin;
        thigh_i  = e.th;
        tlow_i   = e.tl;
        @(negedge clk);
        obs = {i2c_scl_o, scl_fall_o, scl_rise_o, sample_tick_o, drive_tick_o,
               stretching_o, stretch_timeout_o, idle_o};
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        logic [7:0] obs;
        do_reset(1'b1);
        @(negedge clk);
        obs = {i2c_scl_o, scl_fall_o, scl_rise_o, sample_tick_o, drive_tick_o,
               stretching_o, stretch_timeout_o, idle_o};
        n_checks++;
        if (obs !== 8'b1000_0001) begin
            n_errors++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b1000_0001);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] obs;
        stretch_en_i = 1'b0;
        stretch_limit_i = '0;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(4, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            gen_low(6, 1 << 30);
            gen_high(4, 1'b1, (p != 2));
        end
        gen_idle(3, 1'b0, 1'b0);
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL basic_4_6 cycle %0d: got %b expected %b", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_min_len();
        logic [7:0] obs;
        stretch_en_i = 1'b0;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(0, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            gen_low(0, 1 << 30);
            gen_high(0, 1'b1, (p != 3));
        end
        gen_idle(2, 1'b0, 1'b0);
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL min_len cycle %0d: got %b expected %b", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_stretch();
        logic [7:0] obs;
        stretch_en_i = 1'b1;
        stretch_limit_i = '0;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(4, 1'b0, 1'b1);
        gen_low(6, 1 << 30);
        gen_wait(25, 1'b1);
        gen_high(4, 1'b1, 1'b1);
        gen_low(6, 1 << 30);
        gen_wait(1, 1'b1);
        gen_high(4, 1'b1, 1'b0);
        gen_idle(2, 1'b0, 1'b0);
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL stretch cycle %0d: got %b expected %b", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] obs;
        stretch_en_i = 1'b1;
        stretch_limit_i = 20'd8;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(4, 1'b0, 1'b1);
        gen_low(6, 1 << 30);
        gen_wait(8, 1'b1);          // release on the limit cycle: no timeout
        gen_high(4, 1'b1, 1'b1);
        gen_low(6, 1 << 30);
        gen_timeout(8);
        gen_idle(4, 1'b1, 1'b1);    // flag set, no restart while enabled
        gen_idle(1, 1'b0, 1'b1);    // one disabled cycle clears it
        gen_idle(1, 1'b1, 1'b0);
        gen_high(2, 1'b0, 1'b1);
        gen_low(3, 0);
        gen_wait(2, 1'b0);          // released while disabled: park, no rise
        gen_idle(2, 1'b0, 1'b0);
        gen_idle(1, 1'b1, 1'b0);
        gen_high(3, 1'b0, 1'b1);
        gen_low(2, 1 << 30);
        gen_timeout(8);
        gen_idle(2, 1'b1, 1'b1);
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, q[i].exp);
            end
        end
        // Reset also clears the sticky flag, even with clk_en held high.
        do_reset(1'b1);
        @(negedge clk);
        n_checks++;
        if (stretch_timeout_o !== 1'b0 || idle_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_reset_clear: got to=%b idle=%b expected to=0 idle=1",
                     stretch_timeout_o, idle_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_disable_mid_low();
        logic [7:0] obs;
        stretch_en_i = 1'b0;
        stretch_limit_i = '0;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(4, 1'b0, 1'b1);
        gen_low(6, 2);
        gen_idle(6, 1'b0, 1'b0);
        do_reset(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL disable_mid_low cycle %0d: got %b expected %b",
                         i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_low();
        logic [7:0] obs;
        int stop;
        stretch_en_i = 1'b0;
        q.delete();
        gen_idle(1, 1'b1, 1'b0);
        gen_high(3, 1'b0, 1'b1);
        gen_low(6, 1 << 30);
        stop = q.size() - 3;        // leave the DUT three cycles into the low phase
        do_reset(1'b0);
        for (int i = 0; i < stop; i++) begin
            apply_cycle(q[i], obs);
            n_checks++;
            if (obs !== q[i].exp) begin
                n_errors++;
                $display("FAIL reset_mid_low_pre cycle %0d: got %b expected %b",
                         i, obs, q[i].exp);
            end
        end
        do_reset(1'b1);
        @(negedge clk);
        obs = {i2c_scl_o, scl_fall_o, scl_rise_o, sample_tick_o, drive_tick_o,
               stretching_o, stretch_timeout_o, idle_o};
        n_checks++;
        if (obs !== 8'b1000_0001) begin
            n_errors++;
            $display("FAIL reset_mid_low: got %b expected %b", obs, 8'b1000_0001);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [7:0] obs;
        for (int r = 0; r < 6; r++) begin
            stretch_en_i    = 1'($urandom_range(0, 1));
            stretch_limit_i = ($urandom_range(0, 1) != 0) ? 20'd7 : 20'd0;
            q.delete();
            gen_idle(int'($urandom_range(1, 3)), 1'b0, 1'b0);
            gen_idle(1, 1'b1, 1'b0);
            gen_high(int'($urandom_range(0, 9)), 1'b0, 1'b1);
            for (int p = 0; p < 8; p++) begin
                gen_low(int'($urandom_range(0, 9)), 1 << 30);
                if (stretch_en_i) gen_wait(int'($urandom_range(1, 7)), 1'b1);
                gen_high(int'($urandom_range(0, 9)), 1'b1, (p != 7));
            end
            gen_idle(2, 1'b0, 1'b0);
            do_reset(1'b0);
            for (int i = 0; i < q.size(); i++) begin
                apply_cycle(q[i], obs);
                n_checks++;
                if (obs !== q[i].exp) begin
                    n_errors++;
                    $display("FAIL random run %0d cycle %0d: got %b expected %b",
                             r, i, obs, q[i].exp);
                end
            end
        end
    endtask

    initial begin
        reset_i         = 1'b1;
        clk_en_i        = 1'b0;
        thigh_i         = '0;
        tlow_i          = '0;
        stretch_en_i    = 1'b0;
        scl_i           = 1'b1;
        stretch_limit_i = '0;
        test_reset();
        test_basic();
        test_min_len();
        test_stretch();
        test_timeout();
        test_disable_mid_low();
        test_reset_mid_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
